// File: rtl/score_countdown.sv
// Down-counting score/lives keeper: synchronized, edge-qualified press decrements
// Count from START to zero, with Empty, one-cycle Underflow and a seven-segment digit.
module score_countdown #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned START = 7
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Press,
  input  logic             Load,
  output logic [WIDTH-1:0] Count,
  output logic             Empty,
  output logic             Underflow,
  output logic [6:0]       Hex
);

  typedef enum logic {
    RELEASED = 1'b0,
    HELD     = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   s1_q;
  logic   s2_q;
  logic   dec_c;

  // Two-flop synchronizer for the asynchronous press input
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= Press;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RELEASED;
    end else begin
      state_q <= state_d;
    end
  end

  // A press qualifies only once it has been seen on two consecutive edges,
  // so a single-edge glitch that ripples through s2 is ignored.
  always_comb begin
    state_d = state_q;
    dec_c   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s2_q && s1_q) begin
          state_d = HELD;
          dec_c   = 1'b1;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = RELEASED;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Load beats a same-cycle decrement; decrement saturates at zero
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Count     <= WIDTH'(START);
      Underflow <= 1'b0;
    end else if (Load) begin
      Count     <= WIDTH'(START);
      Underflow <= 1'b0;
    end else if (dec_c) begin
      if (Count != '0) begin
        Count     <= Count - WIDTH'(1);
        Underflow <= 1'b0;
      end else begin
        Underflow <= 1'b1;
      end
    end else begin
      Underflow <= 1'b0;
    end
  end

  assign Empty = (Count == '0);

  // Active-low {g,f,e,d,c,b,a}; anything above 9 blanks the digit
  always_comb begin
    Hex = 7'b1111111;
    case (32'(Count))
      32'd0: Hex = 7'b1000000;
      32'd1: Hex = 7'b1111001;
      32'd2: Hex = 7'b0100100;
      32'd3: Hex = 7'b0110000;
      32'd4: Hex = 7'b0011001;
      32'd5: Hex = 7'b0010010;
      32'd6: Hex = 7'b0000010;
      32'd7: Hex = 7'b1111000;
      32'd8: Hex = 7'b0000000;
      32'd9: Hex = 7'b0010000;
      default: Hex = 7'b1111111;
    endcase
  end

endmodule
